// File: rtl/serial_word_collect.sv
// serial_word_collect: assembles a serial bit stream into WIDTH-bit words behind a one-deep valid/ready output register.
module serial_word_collect #(
  parameter int WIDTH     = 32,
  parameter bit LSB_FIRST = 1'b1,
  parameter int TIMEOUT   = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     bit_in,
  input  logic                     bit_vld,
  input  logic                     frame_start,
  output logic [WIDTH-1:0]         word_out,
  output logic                     word_vld,
  input  logic                     word_rdy,
  output logic [$clog2(WIDTH)-1:0] bit_cnt,
  output logic                     overflow,
  output logic                     abort
);
  localparam int CW = $clog2(WIDTH);
  localparam int GW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] COLLECT = 1'b1;
  logic [0:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d, eff_cnt, pos;
  logic [GW-1:0]    gap_q, gap_d;
  logic [WIDTH-1:0] shift_q, shift_d, word_q, word_d, wr_word;
  logic             vld_q, vld_d, ovf_q, ovf_d, abort_q, abort_d;
  logic             done, load, idle_gap, timeout;
  always_comb begin
    eff_cnt  = frame_start ? '0 : cnt_q;
    pos      = LSB_FIRST ? eff_cnt : CW'(WIDTH - 1) - eff_cnt;
    // a fresh word starts from zeros so no bit of an older word can leak through
    wr_word      = (eff_cnt == '0) ? '0 : shift_q;
    wr_word[pos] = bit_in;
    done     = bit_vld && (eff_cnt == CW'(WIDTH - 1));
    idle_gap = (TIMEOUT > 0) && (state_q == COLLECT) && !bit_vld && !frame_start;
    timeout  = idle_gap && (gap_q == GW'(TIMEOUT - 1));
    gap_d    = (idle_gap && !timeout) ? gap_q + 1'b1 : '0;
    cnt_d    = bit_vld ? (done ? '0 : eff_cnt + 1'b1) : ((frame_start || timeout) ? '0 : cnt_q);
    state_d  = (cnt_d != '0) ? COLLECT : IDLE;
    shift_d  = bit_vld ? wr_word : shift_q;
    load     = done && (!vld_q || word_rdy);
    vld_d    = load || (vld_q && !word_rdy);
    word_d   = load ? wr_word : word_q;
    ovf_d    = done && vld_q && !word_rdy;
    abort_d  = timeout;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      gap_q   <= '0;
      shift_q <= '0;
      word_q  <= '0;
      vld_q   <= 1'b0;
      ovf_q   <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      shift_q <= shift_d;
      word_q  <= word_d;
      vld_q   <= vld_d;
      ovf_q   <= ovf_d;
      abort_q <= abort_d;
    end
  end
  assign word_out = word_q;
  assign word_vld = vld_q;
  assign bit_cnt  = cnt_q;
  assign overflow = ovf_q;
  assign abort    = abort_q;
endmodule

// File: tb/tb_serial_word_collect.sv
// tb_serial_word_collect: directed checks of an LSB-first (timeout 4) and an MSB-first (no timeout) collector.
module tb_serial_word_collect;
  logic        clk = 1'b0;
  logic        rst, bit_in, m_bit, bit_vld, frame_start, word_rdy;
  logic [31:0] word_out, m_out;
  logic        word_vld, m_vld, overflow, m_ovf, abort, m_abort;
  logic [4:0]  bit_cnt, m_cnt;
  int          checks = 0;
  int          failures = 0;
  always #5 clk = ~clk;
  serial_word_collect #(.WIDTH(32), .LSB_FIRST(1'b1), .TIMEOUT(4)) u_lsb (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_vld(bit_vld), .frame_start(frame_start),
    .word_out(word_out), .word_vld(word_vld), .word_rdy(word_rdy), .bit_cnt(bit_cnt),
    .overflow(overflow), .abort(abort));
  serial_word_collect #(.WIDTH(32), .LSB_FIRST(1'b0), .TIMEOUT(0)) u_msb (
    .clk(clk), .rst(rst), .bit_in(m_bit), .bit_vld(bit_vld), .frame_start(frame_start),
    .word_out(m_out), .word_vld(m_vld), .word_rdy(word_rdy), .bit_cnt(m_cnt),
    .overflow(m_ovf), .abort(m_abort));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  // the MSB-first instance receives the same word mirrored, so both should assemble w
  task automatic send_bits(input logic [31:0] w, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      @(negedge clk);
      bit_in = w[i];
      m_bit = w[31-i];
      bit_vld = 1'b1;
      frame_start = 1'b0;
    end
  endtask
  initial begin
    logic [31:0] w;
    rst = 1'b1; bit_in = 1'b0; m_bit = 1'b0; bit_vld = 1'b0; frame_start = 1'b0; word_rdy = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_out", word_out, 32'h0);
    chk("rst_vld", word_vld, 32'h0);
    chk("rst_cnt", bit_cnt, 32'h0);
    chk("rst_ovf", overflow, 32'h0);
    chk("rst_abort", abort, 32'h0);
    chk("rst_m_vld", m_vld, 32'h0);
    rst = 1'b0;
    w = 32'hA5C3_0F81;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      chk("t1_cnt", bit_cnt, i);
      chk("t2_cnt", m_cnt, i);
      bit_in = w[i];
      m_bit = w[31-i];
      bit_vld = 1'b1;
    end
    @(negedge clk);
    bit_vld = 1'b0;
    chk("t1_out", word_out, 32'hA5C3_0F81);
    chk("t1_vld", word_vld, 32'h1);
    chk("t1_cnt_wrap", bit_cnt, 32'h0);
    chk("t2_out", m_out, 32'hA5C3_0F81);
    chk("t2_vld", m_vld, 32'h1);
    chk("t2_cnt_wrap", m_cnt, 32'h0);
    @(negedge clk);
    chk("t1_vld_drop", word_vld, 32'h0);
    chk("t2_vld_drop", m_vld, 32'h0);
    word_rdy = 1'b0;
    send_bits(32'h1, 0, 31);
    send_bits(32'h2, 0, 30);
    chk("t3_hold_out", word_out, 32'h1);
    chk("t3_hold_vld", word_vld, 32'h1);
    chk("t3_no_ovf_yet", overflow, 32'h0);
    send_bits(32'h2, 31, 31);
    @(negedge clk);
    bit_vld = 1'b0;
    chk("t3_ovf", overflow, 32'h1);
    chk("t3_kept_out", word_out, 32'h1);
    chk("t3_kept_vld", word_vld, 32'h1);
    @(negedge clk);
    chk("t3_ovf_pulse", overflow, 32'h0);
    chk("t3_still_out", word_out, 32'h1);
    word_rdy = 1'b1;
    @(negedge clk);
    chk("t3_drained", word_vld, 32'h0);
    word_rdy = 1'b0;
    send_bits(32'h1, 0, 31);
    send_bits(32'h2, 0, 30);
    chk("t4_first_out", word_out, 32'h1);
    chk("t4_first_vld", word_vld, 32'h1);
    @(negedge clk);
    bit_in = 1'b0;
    m_bit = 1'b0;
    word_rdy = 1'b1;
    @(negedge clk);
    bit_vld = 1'b0;
    word_rdy = 1'b0;
    chk("t4_out", word_out, 32'h2);
    chk("t4_vld", word_vld, 32'h1);
    chk("t4_no_ovf", overflow, 32'h0);
    @(negedge clk);
    chk("t4_hold_out", word_out, 32'h2);
    chk("t4_no_ovf2", overflow, 32'h0);
    word_rdy = 1'b1;
    @(negedge clk);
    chk("t4_drained", word_vld, 32'h0);
    send_bits(32'h3FF, 0, 9);
    @(negedge clk);
    bit_vld = 1'b0;
    chk("t5_cnt10", bit_cnt, 32'd10);
    repeat (2) @(negedge clk);
    @(negedge clk);
    chk("t5_gap3_abort", abort, 32'h0);
    chk("t5_gap3_cnt", bit_cnt, 32'd10);
    @(negedge clk);
    chk("t5_abort", abort, 32'h1);
    chk("t5_abort_cnt", bit_cnt, 32'h0);
    @(negedge clk);
    chk("t5_abort_pulse", abort, 32'h0);
    send_bits(32'h1234_5678, 0, 31);
    @(negedge clk);
    bit_vld = 1'b0;
    chk("t5_clean_out", word_out, 32'h1234_5678);
    chk("t5_clean_vld", word_vld, 32'h1);
    send_bits(32'hCAFE_F00D, 0, 9);
    @(negedge clk);
    bit_vld = 1'b0;
    repeat (2) @(negedge clk);
    chk("t5_short_cnt", bit_cnt, 32'd10);
    send_bits(32'hCAFE_F00D, 10, 31);
    @(negedge clk);
    bit_vld = 1'b0;
    chk("t5_short_out", word_out, 32'hCAFE_F00D);
    chk("t5_short_vld", word_vld, 32'h1);
    chk("t5_short_abort", abort, 32'h0);
    send_bits(32'h0, 0, 16);
    @(negedge clk);
    frame_start = 1'b1;
    bit_in = 1'b1;
    m_bit = 1'b1;
    bit_vld = 1'b1;
    send_bits(32'hFFFF_FFFF, 1, 1);
    chk("t6_fs_cnt", bit_cnt, 32'h1);
    send_bits(32'hFFFF_FFFF, 2, 31);
    @(negedge clk);
    bit_vld = 1'b0;
    chk("t6_out", word_out, 32'hFFFF_FFFF);
    chk("t6_vld", word_vld, 32'h1);
    chk("t6_no_abort", abort, 32'h0);
    word_rdy = 1'b0;
    send_bits(32'hDEAD_BEEF, 0, 31);
    send_bits(32'hDEAD_BEEF, 0, 9);
    @(negedge clk);
    bit_vld = 1'b0;
    chk("t6_pre_rst_vld", word_vld, 32'h1);
    chk("t6_pre_rst_cnt", bit_cnt, 32'd10);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_out", word_out, 32'h0);
    chk("t6_rst_vld", word_vld, 32'h0);
    chk("t6_rst_cnt", bit_cnt, 32'h0);
    chk("t6_rst_ovf", overflow, 32'h0);
    chk("t6_rst_abort", abort, 32'h0);
    rst = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
